// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - digit count, hex segment table and blank code for the 8-digit scanner
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a} per nibble, entry 0 in the low byte; dp held off.
  localparam logic [16*8-1:0] SEG_LUT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational hex nibble to active-low segments {g,f,e,d,c,b,a}
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[{nibble, 3'b000} +: 7];

endmodule

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - multiplexed 8-digit seven-segment scanner; SEG7_BLANK_EN blanks leading zeros
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV   = 100000,
  parameter int NUM_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0]           cnt;
  logic [2:0]              idx;
  logic [4*NUM_DIGITS-1:0] shadow_data;
  logic [NUM_DIGITS-1:0]   shadow_dp;

  logic                    frame_start;
  logic                    cnt_wrap;
  logic [4*NUM_DIGITS-1:0] cur_data;
  logic [NUM_DIGITS-1:0]   cur_dp;
  logic [3:0]              nibble;
  logic [6:0]              dec_seg;
  logic                    blank;

  assign frame_start = (cnt == '0) && (idx == '0);
  assign cnt_wrap    = (cnt == CW'(SCAN_DIV - 1));

  // The snapshot taken at frame start is forwarded so digit 0 already shows the new frame.
  assign cur_data = frame_start ? data : shadow_data;
  assign cur_dp   = frame_start ? dp   : shadow_dp;
  assign nibble   = cur_data[{idx, 2'b00} +: 4];

  seg7_decode u_decode (
    .nibble (nibble),
    .seg    (dec_seg)
  );

`ifdef SEG7_BLANK_EN
  logic [2:0] msd;

  always_comb begin
    msd = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (cur_data[4*k +: 4] != 4'h0) msd = 3'(k);
    end
  end

  // idx > msd already excludes digit 0.
  assign blank = (idx > msd) && !cur_dp[idx];
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt         <= '0;
      idx         <= '0;
      shadow_data <= '0;
      shadow_dp   <= '0;
      an          <= '1;
      seg         <= SEG_BLANK;
    end else begin
      cnt <= cnt_wrap ? '0 : cnt + 1'b1;
      if (cnt_wrap) idx <= idx + 3'd1;
      if (frame_start) begin
        shadow_data <= data;
        shadow_dp   <= dp;
      end
      if (blank) begin
        an  <= '1;
        seg <= SEG_BLANK;
      end else begin
        an  <= ~(NUM_DIGITS'(1) << idx);
        seg <= {~cur_dp[idx], dec_seg};
      end
    end
  end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter SCAN_DIV, default 100000, clock cycles each digit is lit; legal range 2..2^24.
REQ-002 Parameter NUM_DIGITS, default 8, digit count; fixed at 8.
REQ-003 Port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port rstn  input  1  synchronous, active-low reset.
REQ-005 Port data  input  32  value to display; nibble k drives digit k; consumed from the CPU top's reg_data output.
REQ-006 Port dp  input  8  decimal-point request per digit, 1 = lit.
REQ-007 Port an  output  8  digit anodes, active-low, registered.
REQ-008 Port seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low, registered.

Function
REQ-009 The divider counter cnt SHALL count 0..SCAN_DIV-1 and wrap to 0; its width SHALL be the ceiling of log2(SCAN_DIV).
REQ-010 The digit index idx (3 bits) SHALL advance by 1 on the cycle cnt wraps, and SHALL wrap from 7 to 0.
REQ-011 A frame SHALL start when cnt==0 and idx==0; in that cycle data and dp SHALL be captured into shadow registers.
REQ-012 The display SHALL use only the shadow registers; data changes inside a frame SHALL NOT affect the display until the next frame start.
REQ-013 an and seg SHALL be registered from the current idx and shadow, one cycle behind idx.
REQ-014 an SHALL drive exactly one bit low (bit idx) per cycle, except for digits blanked under REQ-020.
REQ-015 seg[6:0] SHALL be the hex decode of shadow nibble idx: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E (dp bit shown as 1).
REQ-016 seg[7] SHALL be 0 when shadow dp[idx]==1, otherwise 1.
REQ-017 Each digit SHALL stay lit for exactly SCAN_DIV cycles; a full frame SHALL be 8*SCAN_DIV cycles with no gap cycles.

Reset
REQ-018 While rstn==0 at a clock edge: cnt=0, idx=0, shadow data=0, shadow dp=0, an=8'hFF, seg=8'hFF.
REQ-019 In the first cycle after rstn rises, a frame SHALL start (REQ-011); reset asserted mid-frame SHALL abort the scan and restart it at digit 0.

Configuration
REQ-020 With SEG7_BLANK_EN defined, digits above the most significant non-zero shadow nibble SHALL be blanked (an bit high, seg=8'hFF) unless that digit's shadow dp bit is 1; digit 0 SHALL never be blanked.
REQ-021 Without SEG7_BLANK_EN, all 8 digits SHALL be scanned and displayed, including leading zeros.

Structure
REQ-022 Package seg7_pkg SHALL hold NUM_DIGITS, the 16-entry segment decode constant table and the blank code 8'hFF.
REQ-023 The combinational nibble-to-segment decode SHALL be a sub-module, seg7_decode; scan, shadow and output registers SHALL stay in seg7_scan.

Verification (SCAN_DIV=4 unless stated)
REQ-024 Reset held low for 10 cycles with data=32'h12345678 -> an=FF and seg=FF every cycle.
REQ-025 Release reset with data=32'h12345678, dp=0 -> an steps FE,FD,FB,F7,EF,DF,BF,7F with 4 cycles each; seg shows 80 (digit 0) ... F9 (digit 7), then returns to FE.
REQ-026 Change data to 32'hFFFFFFFF while digit 3 is lit -> digits 4..7 still show the old nibbles; after the wrap to an=FE, seg=8E.
REQ-027 dp=8'h01, data=0 -> digit 0 shows seg=40 and all other digits show C0 (build without macro).
REQ-028 SEG7_BLANK_EN, data=32'h000000A5 -> digit 0 shows 92, digit 1 shows 88, digits 2..7 have an bit high and seg=FF; with data=0, only digit 0 is lit, showing C0.
REQ-029 Assert rstn low for 1 cycle while digit 5 is lit -> the next edge gives an=FF, seg=FF; after release the scan restarts at digit 0 with a new snapshot.
